// File: rtl/clken_pkg.sv
// Shared defaults and slice helper for the clock-enable generator.
package clken_pkg;

    localparam int NCH_DEF   = 4;
    localparam int DIVW_DEF  = 16;
    localparam int MAX_VEC_W = 1024;
    localparam int MAX_DIVW  = 32;

    // Returns the w-bit field at channel idx of a flattened vector, zero-extended.
    function automatic logic [MAX_DIVW-1:0] ch_slice(input logic [MAX_VEC_W-1:0] vec,
                                                     input int idx,
                                                     input int w);
        logic [MAX_VEC_W-1:0] shifted;
        logic [MAX_VEC_W-1:0] mask;
        shifted = vec >> (idx * w);
        mask    = (MAX_VEC_W'(1) << w) - MAX_VEC_W'(1);
        return MAX_DIVW'(shifted & mask);
    endfunction

endpackage

// File: rtl/clken_ch.sv
// One clock-enable channel: down-counter with active/pending divisor and tick/toggle outputs.
module clken_ch #(
    parameter int               DIVW    = 16,
    parameter logic [DIVW-1:0]  DIV_RST = DIVW'(1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load_i,
    input  logic            sync_i,
    input  logic            en_i,
    input  logic [DIVW-1:0] div_i,
    output logic            tick_o,
    output logic            tog_o,
    output logic            pend_o
);

    logic [DIVW-1:0] cnt_q, cnt_d;
    logic [DIVW-1:0] div_act_q, div_act_d;
    logic [DIVW-1:0] div_pend_q, div_pend_d;
    logic            pend_q, pend_d;
    logic            tick_q, tick_d;
    logic            tog_q, tog_d;

    logic            running;
    logic [DIVW-1:0] div_next;

    assign running  = en_i && (div_act_q != '0);
    assign div_next = pend_q ? div_pend_q : div_act_q;

    always_comb begin
        cnt_d      = cnt_q;
        div_act_d  = div_act_q;
        div_pend_d = div_pend_q;
        pend_d     = pend_q;
        tick_d     = 1'b0;
        tog_d      = tog_q;

        if (load_i && sync_i) begin
            div_act_d  = div_i;
            div_pend_d = div_i;
            pend_d     = 1'b0;
            cnt_d      = '0;
            tog_d      = 1'b0;
        end else if (sync_i) begin
            if (pend_q) begin
                div_act_d = div_pend_q;
            end
            pend_d = 1'b0;
            cnt_d  = '0;
            tog_d  = 1'b0;
        end else begin
            if (running) begin
                if (cnt_q == '0) begin
                    // A zero divisor arriving at the wrap ends this period and parks the channel.
                    tick_d = 1'b1;
                    tog_d  = ~tog_q;
                    cnt_d  = (div_next == '0) ? '0 : div_next - DIVW'(1);
                    if (pend_q) begin
                        div_act_d = div_pend_q;
                        pend_d    = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q - DIVW'(1);
                end
            end else if (pend_q) begin
                div_act_d = div_pend_q;
                pend_d    = 1'b0;
            end
            if (load_i) begin
                div_pend_d = div_i;
                pend_d     = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q      <= '0;
            div_act_q  <= DIV_RST;
            div_pend_q <= '0;
            pend_q     <= 1'b0;
            tick_q     <= 1'b0;
            tog_q      <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            div_act_q  <= div_act_d;
            div_pend_q <= div_pend_d;
            pend_q     <= pend_d;
            tick_q     <= tick_d;
            tog_q      <= tog_d;
        end
    end

    assign tick_o = tick_q;
    assign tog_o  = tog_q;
    assign pend_o = pend_q;

endmodule

// File: rtl/clken_gen.sv
// NCH-channel clock-enable generator; replicates clken_ch and fans out load/sync.
module clken_gen
    import clken_pkg::*;
#(
    parameter int                     NCH     = NCH_DEF,
    parameter int                     DIVW    = DIVW_DEF,
    parameter logic [NCH*DIVW-1:0]    DIV_RST = {NCH{DIVW'(1)}}
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NCH*DIVW-1:0] div_i,
    input  logic                load,
    input  logic                sync,
    input  logic [NCH-1:0]      ch_en,
    output logic [NCH-1:0]      tick,
    output logic [NCH-1:0]      tog,
    output logic [NCH-1:0]      pend
);

    logic [MAX_VEC_W-1:0] div_wide;

    assign div_wide = MAX_VEC_W'(div_i);

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        clken_ch #(
            .DIVW    (DIVW),
            .DIV_RST (DIV_RST[i*DIVW +: DIVW])
        ) u_ch (
            .clk    (clk),
            .rst    (rst),
            .load_i (load),
            .sync_i (sync),
            .en_i   (ch_en[i]),
            .div_i  (DIVW'(ch_slice(div_wide, i, DIVW))),
            .tick_o (tick[i]),
            .tog_o  (tog[i]),
            .pend_o (pend[i])
        );
    end

endmodule

// File: tb/tb_clken_gen.sv
// Directed bench for clken_gen: reset, divisor reload, sync, enable gating, stop/restart, reset mid-count.
module tb_clken_gen;

    logic        clk;
    logic        rst;
    logic [63:0] div_i;
    logic        load;
    logic        sync;
    logic [3:0]  ch_en;
    logic [3:0]  tick;
    logic [3:0]  tog;
    logic [3:0]  pend;

    int n_cmp;
    int n_fail;

    clken_gen #(.NCH(4), .DIVW(16)) dut (
        .clk   (clk),
        .rst   (rst),
        .div_i (div_i),
        .load  (load),
        .sync  (sync),
        .ch_en (ch_en),
        .tick  (tick),
        .tog   (tog),
        .pend  (pend)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %b expected %b", tag, obs, exp);
        end
    endtask

    // Edges T+1..T+11 after a channel-0 tick at T; bit k = expected tick[0].
    logic [11:0] pat2;
    // Expected tick vector for edges s+1..s+14 after a sync with D = {7,5,3,2}.
    logic [3:0]  exp_t3 [14];

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        pat2   = 12'b1001_0010_0000;
        exp_t3 = '{4'hF, 4'h0, 4'h1, 4'h2, 4'h1, 4'h4, 4'h3,
                   4'h8, 4'h1, 4'h2, 4'h5, 4'h0, 4'h3, 4'h0};

        rst   = 1'b1;
        load  = 1'b0;
        sync  = 1'b0;
        ch_en = 4'hF;
        div_i = '0;

        // Reset state and D=1 on every channel
        repeat (2) @(negedge clk);
        chk4("rst_tick", tick, 4'h0);
        chk4("rst_tog",  tog,  4'h0);
        chk4("rst_pend", pend, 4'h0);
        rst = 1'b0;
        @(negedge clk);
        chk4("d1_tick_a", tick, 4'hF);
        chk4("d1_tog_a",  tog,  4'hF);
        @(negedge clk);
        chk4("d1_tick_b", tick, 4'hF);
        chk4("d1_tog_b",  tog,  4'h0);
        @(negedge clk);
        chk4("d1_tick_c", tick, 4'hF);
        chk4("d1_tog_c",  tog,  4'hF);

        // Channel 0 at D=5, reload with 3 two cycles after a tick
        div_i = {16'd1, 16'd1, 16'd1, 16'd5};
        load  = 1'b1;
        sync  = 1'b1;
        @(negedge clk);
        load = 1'b0;
        sync = 1'b0;
        chk4("t2_sync_tick", tick, 4'h0);
        chk4("t2_sync_pend", pend, 4'h0);
        chk4("t2_sync_tog",  tog,  4'h0);
        @(negedge clk);
        chk4("t2_first_tick", tick, 4'hF);
        for (int k = 1; k <= 11; k++) begin
            @(negedge clk);
            chk1("t2_tick0", tick[0], pat2[k]);
            if (k == 1) begin
                div_i = {16'd1, 16'd1, 16'd1, 16'd3};
                load  = 1'b1;
            end
            if (k == 2) begin
                load = 1'b0;
                chk1("t2_pend0_set", pend[0], 1'b1);
            end
            if (k == 5) begin
                chk1("t2_pend0_clr", pend[0], 1'b0);
            end
        end

        // D = {7,5,3,2}, then sync mid-run
        div_i = {16'd7, 16'd5, 16'd3, 16'd2};
        load  = 1'b1;
        @(negedge clk);
        load = 1'b0;
        repeat (4) @(negedge clk);
        sync = 1'b1;
        @(negedge clk);
        sync = 1'b0;
        chk4("t3_sync_tick", tick, 4'h0);
        chk4("t3_sync_tog",  tog,  4'h0);
        chk4("t3_sync_pend", pend, 4'h0);
        for (int j = 0; j < 14; j++) begin
            @(negedge clk);
            chk4("t3_tick", tick, exp_t3[j]);
            if (j == 0) chk4("t3_tog_first", tog, 4'hF);
            if (j == 2) chk4("t3_tog_m2",    tog, 4'hE);
        end

        // Channel 2 (D=5) disabled for 4 cycles with cnt=2
        sync = 1'b1;
        @(negedge clk);
        sync = 1'b0;
        @(negedge clk);
        chk4("t4_tick_all", tick, 4'hF);
        chk1("t4_tog2_start", tog[2], 1'b1);
        repeat (2) @(negedge clk);
        ch_en = 4'b1011;
        for (int k = 4; k <= 9; k++) begin
            @(negedge clk);
            chk1("t4_tick2_idle", tick[2], 1'b0);
            chk1("t4_tog2_hold",  tog[2],  1'b1);
            if (k == 7) ch_en = 4'hF;
        end
        @(negedge clk);
        chk1("t4_tick2_resume", tick[2], 1'b1);
        chk1("t4_tog2_resume",  tog[2],  1'b0);

        // Channel 0 stopped by a zero divisor, then restarted with 4
        sync = 1'b1;
        @(negedge clk);
        sync = 1'b0;
        @(negedge clk);
        chk1("t5_tick0_a1", tick[0], 1'b1);
        div_i = {16'd7, 16'd5, 16'd3, 16'd0};
        load  = 1'b1;
        @(negedge clk);
        load = 1'b0;
        chk1("t5_tick0_a2", tick[0], 1'b0);
        chk1("t5_pend0_a2", pend[0], 1'b1);
        @(negedge clk);
        chk1("t5_tick0_a3", tick[0], 1'b1);
        chk1("t5_tog0_a3",  tog[0],  1'b0);
        chk1("t5_pend0_a3", pend[0], 1'b0);
        repeat (4) begin
            @(negedge clk);
            chk1("t5_tick0_stopped", tick[0], 1'b0);
            chk1("t5_tog0_stopped",  tog[0],  1'b0);
        end
        div_i = {16'd7, 16'd5, 16'd3, 16'd4};
        load  = 1'b1;
        @(negedge clk);
        load = 1'b0;
        chk1("t5_pend0_a8", pend[0], 1'b1);
        chk1("t5_tick0_a8", tick[0], 1'b0);
        @(negedge clk);
        chk1("t5_pend0_a9", pend[0], 1'b0);
        chk1("t5_tick0_a9", tick[0], 1'b0);
        @(negedge clk);
        chk1("t5_tick0_a10", tick[0], 1'b1);
        repeat (3) begin
            @(negedge clk);
            chk1("t5_tick0_gap", tick[0], 1'b0);
        end
        @(negedge clk);
        chk1("t5_tick0_a14", tick[0], 1'b1);

        // load+sync together at D=6, then reset mid-count
        div_i = {16'd6, 16'd6, 16'd6, 16'd6};
        load  = 1'b1;
        sync  = 1'b1;
        @(negedge clk);
        load = 1'b0;
        sync = 1'b0;
        chk4("t6_pend_b",  pend, 4'h0);
        chk4("t6_tick_b",  tick, 4'h0);
        chk4("t6_tog_b",   tog,  4'h0);
        @(negedge clk);
        chk4("t6_tick_b1", tick, 4'hF);
        chk4("t6_tog_b1",  tog,  4'hF);
        repeat (5) begin
            @(negedge clk);
            chk4("t6_tick_gap", tick, 4'h0);
        end
        @(negedge clk);
        chk4("t6_tick_b7", tick, 4'hF);
        @(negedge clk);
        div_i = {16'd2, 16'd2, 16'd2, 16'd2};
        load  = 1'b1;
        @(negedge clk);
        load = 1'b0;
        chk4("t6_pend_b9", pend, 4'hF);
        rst = 1'b1;
        @(negedge clk);
        chk4("t6_rst_tick", tick, 4'h0);
        chk4("t6_rst_tog",  tog,  4'h0);
        chk4("t6_rst_pend", pend, 4'h0);
        rst = 1'b0;
        @(negedge clk);
        chk4("t6_post_rst_tick", tick, 4'hF);
        chk4("t6_post_rst_tog",  tog,  4'hF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/clken_gen.md
# clken_gen

Parametrised clock-enable generator, successor to the fixed clock divider. It produces NCH independent tick strobes (and matching toggle outputs) from the single system clock, with runtime-programmable divide ratios. Voices, ADSR, modulation and multiplier logic use these strobes instead of derived clocks. The whole synth stays on one clock domain; divider changes apply glitch-free at each channel's wrap.

## Interface
Parameters:
- NCH, 4: number of channels.
- DIVW, 16: divider width per channel.
- DIV_RST, {NCH{16'd1}}: flattened reset divide values; channel i at [i*DIVW +: DIVW].

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- div_i  in  NCH*DIVW  new divide values; channel i at [i*DIVW +: DIVW].
- load  in  1  single-cycle pulse; captures div_i into the pending registers.
- sync  in  1  single-cycle pulse; restarts all channels phase-aligned.
- ch_en  in  NCH  per-channel run enable.
- tick  out  NCH  one-cycle strobe per channel period, registered.
- tog  out  NCH  toggles on every tick (square wave, period 2·D), registered.
- pend  out  NCH  high while a loaded value is waiting to be applied.

## Operation
- Per channel: down-counter cnt, active divisor div_act, pending divisor div_pend, pending flag.
- Reset: cnt=0, tick=0, tog=0, pend=0, div_act=DIV_RST slice, div_pend=0.
- Running (ch_en[i]=1, div_act≠0): if cnt==0, tick<=1, tog<=~tog, cnt<=D−1, where D = div_pend if pend else div_act; when pend is set, div_act<=div_pend and pend<=0. Otherwise tick<=0, cnt<=cnt−1.
- Tick period is exactly D cycles. D=1 gives tick high every cycle, with tog toggling every cycle.
- div_act==0: channel is stopped regardless of ch_en. tick=0; tog and cnt hold.
- ch_en[i]=0: tick=0, cnt and tog hold. Re-enable resumes from the held count, with no extra tick.
- Stopped or disabled channel with pend set: div_act<=div_pend and pend<=0 on the next edge.
- load: div_pend<=div_i for all channels and pend<=all ones. A load while pend is still set overwrites the pending value; the last load wins.
- sync: for all channels, cnt<=0, tick<=0, tog<=0. Pending values are applied immediately (div_act<=div_pend, pend<=0). All enabled channels tick together on the following edge.
- load and sync in the same cycle: div_i goes directly into div_act, pend<=0, then the sync restart.
- rst has priority over load and sync.

## Timing
- Reset released at edge k, ch_en=1: first tick is high after edge k+1. Subsequent ticks are spaced every D cycles.
- sync at edge s: tick=0 after s; all enabled channels have tick=1 after s+1.
- A new divisor takes effect at the channel's next wrap. The period in progress completes with the old value, so no runt period occurs.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Package clken_pkg: default DIVW and NCH, and a function to extract channel slices.
- Sub-module clken_ch: one channel (counter, div_act/div_pend, pend, tick/tog). The top generates NCH instances and fans out load and sync.
- The top level contains no logic beyond slicing and concatenation.

## Test plan
- Reset, DIV_RST=1 on all channels, ch_en=4'hF: tick=4'hF every cycle from the second cycle after rst falls; tog toggles every cycle.
- Channel 0 running at D=5, load D=3 two cycles after a tick: the next tick arrives 5 cycles after the previous one, then every 3 cycles. pend[0] drops at the wrap.
- D={7,5,3,2}, then sync mid-run: all four ticks are high together one cycle after sync, then diverge at periods 7, 5, 3 and 2. tog=0 after sync.
- Channel 2 disabled for 4 cycles with cnt=2: no tick and tog holds while disabled. After re-enable the tick arrives 3 cycles later.
- load with div_i slice 0 = 0: channel 0 stops after its current period completes. A later load of 4 applies on the next edge and the channel restarts ticking every 4 cycles.
- load and sync in the same cycle with D=6: pend stays 0, all channels tick one cycle later, then every 6 cycles. rst asserted mid-count returns every output to its reset value on the next edge.
